// File: rtl/screen_sequencer.sv
// Frame scheduler for the tank game display.
// Commits screen changes on frame boundaries only.
module screen_sequencer #(
  parameter int WIN_HOLD_FRAMES  = 180,
  parameter int HIST_HOLD_FRAMES = 600,
  parameter int FCNT_W           = 10
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       hist_btn,
  input  logic       green_base_hit,
  input  logic       red_base_hit,
  output logic       enable1,
  output logic       enable2,
  output logic       enable3,
  output logic       enable4,
  output logic       enable5,
  output logic       game_rst,
  output logic [1:0] His1,
  output logic [1:0] His2,
  output logic [1:0] His3,
  output logic [3:0] green_score,
  output logic [3:0] red_score,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_PLAY  = 3'd1;
  localparam logic [2:0] S_WIN_G = 3'd2;
  localparam logic [2:0] S_WIN_R = 3'd3;
  localparam logic [2:0] S_HIST  = 3'd4;

  localparam logic [1:0] R_GREEN = 2'b01;
  localparam logic [1:0] R_RED   = 2'b10;
  localparam logic [1:0] R_DRAW  = 2'b11;

  localparam logic [FCNT_W-1:0] WIN_LAST =
    FCNT_W'(WIN_HOLD_FRAMES - 1);
  localparam logic [FCNT_W-1:0] HIST_LAST =
    FCNT_W'(HIST_HOLD_FRAMES - 1);

  logic [2:0]        state_q, state_d;
  logic [4:0]        en_q, en_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              st_pq, st_pd;
  logic              hb_pq, hb_pd;
  logic              gh_pq, gh_pd;
  logic              rh_pq, rh_pd;
  logic              grst_q, grst_d;
  logic [1:0]        his1_q, his1_d;
  logic [1:0]        his2_q, his2_d;
  logic [1:0]        his3_q, his3_d;
  logic [3:0]        gsc_q, gsc_d;
  logic [3:0]        rsc_q, rsc_d;

  logic       in_play;
  logic       start_ev;
  logic       hist_ev;
  logic       ghit_ev;
  logic       rhit_ev;
  logic       push;
  logic [1:0] code;
  logic       win_to;
  logic       hist_to;

  assign in_play  = (state_q == S_PLAY);
  assign start_ev = st_pq | start_btn;
  assign hist_ev  = hb_pq | hist_btn;
  assign ghit_ev  = gh_pq | (green_base_hit & in_play);
  assign rhit_ev  = rh_pq | (red_base_hit & in_play);
  assign win_to   = (fcnt_q == WIN_LAST);
  assign hist_to  = (fcnt_q == HIST_LAST);

  // Pending flags: sticky between frame ticks, dropped on every tick.
  always_comb begin
    st_pd = start_ev;
    hb_pd = hist_ev;
    gh_pd = ghit_ev;
    rh_pd = rhit_ev;
    if (frame_tick) begin
      st_pd = 1'b0;
      hb_pd = 1'b0;
      gh_pd = 1'b0;
      rh_pd = 1'b0;
    end
  end

  // Next-state decision, only evaluated on a frame tick.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    code    = 2'b00;
    if (frame_tick) begin
      case (state_q)
        S_INIT: begin
          if (start_ev)     state_d = S_PLAY;
          else if (hist_ev) state_d = S_HIST;
        end
        S_PLAY: begin
          if (ghit_ev && rhit_ev) begin
            state_d = S_HIST;
            push    = 1'b1;
            code    = R_DRAW;
          end else if (rhit_ev) begin
            state_d = S_WIN_G;
            push    = 1'b1;
            code    = R_GREEN;
          end else if (ghit_ev) begin
            state_d = S_WIN_R;
            push    = 1'b1;
            code    = R_RED;
          end
        end
        S_WIN_G, S_WIN_R: begin
          if (start_ev || win_to) state_d = S_HIST;
        end
        S_HIST: begin
          if (start_ev)     state_d = S_PLAY;
          else if (hist_to) state_d = S_INIT;
        end
        default: state_d = S_INIT;
      endcase
    end
  end

  // History, scores, frame counter, enables and round reset.
  always_comb begin
    his1_d = his1_q;
    his2_d = his2_q;
    his3_d = his3_q;
    gsc_d  = gsc_q;
    rsc_d  = rsc_q;
    if (push) begin
      his1_d = code;
      his2_d = his1_q;
      his3_d = his2_q;
      if (code == R_GREEN && gsc_q != 4'hF)
        gsc_d = gsc_q + 4'd1;
      if (code == R_RED && rsc_q != 4'hF)
        rsc_d = rsc_q + 4'd1;
    end
    fcnt_d = fcnt_q;
    if (state_d != state_q)
      fcnt_d = '0;
    else if (frame_tick && fcnt_q != '1)
      fcnt_d = fcnt_q + 1'b1;
    grst_d = (state_d == S_PLAY) && !in_play;
    en_d = 5'b00001;
    case (state_d)
      S_PLAY:  en_d = 5'b00010;
      S_WIN_G: en_d = 5'b00100;
      S_WIN_R: en_d = 5'b01000;
      S_HIST:  en_d = 5'b10000;
      default: en_d = 5'b00001;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_INIT;
      en_q    <= 5'b00001;
      fcnt_q  <= '0;
      st_pq   <= 1'b0;
      hb_pq   <= 1'b0;
      gh_pq   <= 1'b0;
      rh_pq   <= 1'b0;
      grst_q  <= 1'b0;
      his1_q  <= 2'b00;
      his2_q  <= 2'b00;
      his3_q  <= 2'b00;
      gsc_q   <= 4'd0;
      rsc_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      fcnt_q  <= fcnt_d;
      st_pq   <= st_pd;
      hb_pq   <= hb_pd;
      gh_pq   <= gh_pd;
      rh_pq   <= rh_pd;
      grst_q  <= grst_d;
      his1_q  <= his1_d;
      his2_q  <= his2_d;
      his3_q  <= his3_d;
      gsc_q   <= gsc_d;
      rsc_q   <= rsc_d;
    end
  end

  assign enable1     = en_q[0];
  assign enable2     = en_q[1];
  assign enable3     = en_q[2];
  assign enable4     = en_q[3];
  assign enable5     = en_q[4];
  assign game_rst    = grst_q;
  assign His1        = his1_q;
  assign His2        = his2_q;
  assign His3        = his3_q;
  assign green_score = gsc_q;
  assign red_score   = rsc_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer.
// Hold times shortened to 4 (win) and 6 (history).
module tb_screen_sequencer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start_btn = 1'b0;
  logic       hist_btn = 1'b0;
  logic       green_base_hit = 1'b0;
  logic       red_base_hit = 1'b0;
  logic       enable1, enable2, enable3;
  logic       enable4, enable5, game_rst;
  logic [1:0] His1, His2, His3;
  logic [3:0] green_score, red_score;
  logic [2:0] state_dbg;

  int n_chk = 0;
  int n_fail = 0;

  screen_sequencer #(
    .WIN_HOLD_FRAMES (4),
    .HIST_HOLD_FRAMES(6),
    .FCNT_W          (4)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .frame_tick    (frame_tick),
    .start_btn     (start_btn),
    .hist_btn      (hist_btn),
    .green_base_hit(green_base_hit),
    .red_base_hit  (red_base_hit),
    .enable1       (enable1),
    .enable2       (enable2),
    .enable3       (enable3),
    .enable4       (enable4),
    .enable5       (enable5),
    .game_rst      (game_rst),
    .His1          (His1),
    .His2          (His2),
    .His3          (His3),
    .green_score   (green_score),
    .red_score     (red_score),
    .state_dbg     (state_dbg)
  );

  always #5 clock = ~clock;

  function automatic logic [4:0] ens();
    return {enable5, enable4, enable3, enable2, enable1};
  endfunction

  // Drive one cycle of inputs, return #1 after the edge.
  task automatic step(input logic ft, input logic st,
                      input logic hb, input logic gh,
                      input logic rh);
    frame_tick     = ft;
    start_btn      = st;
    hist_btn       = hb;
    green_base_hit = gh;
    red_base_hit   = rh;
    @(posedge clock);
    #1;
    frame_tick     = 1'b0;
    start_btn      = 1'b0;
    hist_btn       = 1'b0;
    green_base_hit = 1'b0;
    red_base_hit   = 1'b0;
  endtask

  // Navigate to the game screen, bounded.
  task automatic goto_play();
    int budget;
    budget = 4;
    while (!enable2 && budget > 0) begin
      step(1, 1, 0, 0, 0);
      budget--;
    end
    n_chk++;
    if (!enable2) begin
      n_fail++;
      $display("FAIL goto_play: enables=%b required play", ens());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    n_chk++;
    if (ens() !== 5'b00001 || game_rst !== 1'b0 ||
        state_dbg !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_out: en=%b rst=%b st=%0d req 00001/0/0",
               ens(), game_rst, state_dbg);
    end
    n_chk++;
    if ({His1, His2, His3} !== 6'b0 ||
        green_score !== 4'd0 || red_score !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_his: his=%b g=%0d r=%0d req 0",
               {His1, His2, His3}, green_score, red_score);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      n_chk++;
      if (ens() !== 5'b00001 || game_rst !== 1'b0 ||
          {His1, His2, His3} !== 6'b0) begin
        n_fail++;
        $display("FAIL idle_tick%0d: en=%b rst=%b his=%b req 00001/0/0",
                 i, ens(), game_rst, {His1, His2, His3});
      end
    end
  endtask

  task automatic test_start();
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0);
      n_chk++;
      if (ens() !== 5'b00001 || game_rst !== 1'b0) begin
        n_fail++;
        $display("FAIL start_wait%0d: en=%b rst=%b req 00001/0",
                 i, ens(), game_rst);
      end
    end
    step(1, 0, 0, 0, 0);
    n_chk++;
    if (ens() !== 5'b00010 || game_rst !== 1'b1 ||
        state_dbg !== 3'd1) begin
      n_fail++;
      $display("FAIL start_t1: en=%b rst=%b st=%0d req 00010/1/1",
               ens(), game_rst, state_dbg);
    end
    step(0, 0, 0, 0, 0);
    n_chk++;
    if (ens() !== 5'b00010 || game_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL start_t2: en=%b rst=%b req 00010/0",
               ens(), game_rst);
    end
    step(0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    n_chk++;
    if (ens() !== 5'b00010 || game_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL play_ignore: en=%b rst=%b req 00010/0",
               ens(), game_rst);
    end
  endtask

  task automatic test_green_win();
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    n_chk++;
    if (ens() !== 5'b00100 || His1 !== 2'b01 ||
        green_score !== 4'd1 || red_score !== 4'd0) begin
      n_fail++;
      $display("FAIL green_win: en=%b his1=%b g=%0d r=%0d req 00100/01/1/0",
               ens(), His1, green_score, red_score);
    end
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      n_chk++;
      if (ens() !== ((i == 4) ? 5'b10000 : 5'b00100)) begin
        n_fail++;
        $display("FAIL win_hold%0d: en=%b req %b", i, ens(),
                 (i == 4) ? 5'b10000 : 5'b00100);
      end
    end
  endtask

  task automatic test_hits_gated();
    step(0, 0, 0, 1, 1);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    n_chk++;
    if (ens() !== 5'b00010 || His1 !== 2'b01) begin
      n_fail++;
      $display("FAIL hit_gate: en=%b his1=%b req 00010/01",
               ens(), His1);
    end
  endtask

  task automatic test_draw();
    step(1, 0, 0, 1, 1);
    n_chk++;
    if (ens() !== 5'b10000 || His1 !== 2'b11 || His2 !== 2'b01 ||
        green_score !== 4'd1 || red_score !== 4'd0) begin
      n_fail++;
      $display("FAIL draw: en=%b h=%b%b g=%0d r=%0d req 10000/1101/1/0",
               ens(), His1, His2, green_score, red_score);
    end
  endtask

  task automatic test_history();
    reset_n = 1'b0;
    step(0, 0, 0, 0, 0);
    reset_n = 1'b1;
    goto_play();
    step(1, 0, 0, 0, 1);
    goto_play();
    step(1, 0, 0, 1, 0);
    n_chk++;
    if (ens() !== 5'b01000 || red_score !== 4'd1) begin
      n_fail++;
      $display("FAIL red_win: en=%b r=%0d req 01000/1",
               ens(), red_score);
    end
    goto_play();
    step(1, 0, 0, 0, 1);
    goto_play();
    step(1, 0, 0, 1, 1);
    n_chk++;
    if (His1 !== 2'b11 || His2 !== 2'b01 || His3 !== 2'b10 ||
        green_score !== 4'd2 || red_score !== 4'd1) begin
      n_fail++;
      $display("FAIL history: h=%b/%b/%b g=%0d r=%0d req 11/01/10/2/1",
               His1, His2, His3, green_score, red_score);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 16; i++) begin
      goto_play();
      step(1, 0, 0, 0, 1);
    end
    n_chk++;
    if (green_score !== 4'd15 || red_score !== 4'd1 ||
        ens() !== 5'b00100) begin
      n_fail++;
      $display("FAIL saturate: g=%0d r=%0d en=%b req 15/1/00100",
               green_score, red_score, ens());
    end
  endtask

  task automatic test_hist_timeout();
    step(1, 1, 0, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      step(0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0);
      n_chk++;
      if (ens() !== ((i == 6) ? 5'b00001 : 5'b10000)) begin
        n_fail++;
        $display("FAIL hist_hold%0d: en=%b req %b", i, ens(),
                 (i == 6) ? 5'b00001 : 5'b10000);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    n_chk++;
    if (ens() !== 5'b10000) begin
      n_fail++;
      $display("FAIL mid_pre: en=%b req 10000", ens());
    end
    step(0, 1, 0, 0, 0);
    reset_n = 1'b0;
    step(0, 0, 0, 0, 0);
    reset_n = 1'b1;
    n_chk++;
    if (ens() !== 5'b00001 || {His1, His2, His3} !== 6'b0 ||
        green_score !== 4'd0 || red_score !== 4'd0 ||
        game_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: en=%b his=%b g=%0d r=%0d rst=%b req 0",
               ens(), {His1, His2, His3}, green_score, red_score,
               game_rst);
    end
    step(1, 0, 0, 0, 0);
    n_chk++;
    if (ens() !== 5'b00001 || game_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_pending: en=%b rst=%b req 00001/0",
               ens(), game_rst);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_green_win();
    test_hits_gated();
    test_draw();
    test_history();
    test_saturate();
    test_hist_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
